// File: rtl/cpu_wb_bus_if_pkg.sv
// Shared types and constants for the CPU-to-Wishbone bridge.
// Bus widths, the stall vector width and the bridge state encoding.
package cpu_wb_bus_if_pkg;

    localparam int REG_BUS = 32;
    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;
    localparam int STALL_BUS_W = 6;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        BUSY       = 2'b01,
        WAIT_STALL = 2'b10
    } wb_state_e;

endpackage

// File: rtl/cpu_wb_bus_if.sv
// Bridge from the core's SRAM-style port to a Wishbone B3 classic master.
// Each CPU access becomes one Wishbone cycle; the pipeline stalls until it ends.
import cpu_wb_bus_if_pkg::*;

module cpu_wb_bus_if #(
    parameter int DW      = REG_BUS,
    parameter int STALL_W = STALL_BUS_W,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic               cpu_ce_i,
    input  logic               cpu_we_i,
    input  logic [DW-1:0]      cpu_addr_i,
    input  logic [3:0]         cpu_sel_i,
    input  logic [DW-1:0]      cpu_data_i,
    output logic [DW-1:0]      cpu_data_o,
    output logic               stallreq_o,
    output logic               bus_err_o,
    output logic [DW-1:0]      wb_adr_o,
    output logic [DW-1:0]      wb_dat_o,
    output logic               wb_we_o,
    output logic [3:0]         wb_sel_o,
    output logic               wb_stb_o,
    output logic               wb_cyc_o,
    input  logic [DW-1:0]      wb_dat_i,
    input  logic               wb_ack_i
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];
    localparam logic [CW-1:0] CNT_MAX = '1;

    wb_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rd_buf_q, rd_buf_d;
    logic [DW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic          cyc_q, cyc_d;
    logic          err_q, err_d;
    logic          drop;

    // Next-state, bus register updates and the combinational CPU-side outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_buf_d   = rd_buf_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        sel_d      = sel_q;
        cyc_d      = cyc_q;
        err_d      = 1'b0;
        drop       = 1'b0;
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        unique case (state_q)
            IDLE: begin
                stallreq_o = cpu_ce_i & ~flush_i;
                if (cpu_ce_i && !flush_i) begin
                    adr_d   = cpu_addr_i;
                    dat_d   = cpu_data_i;
                    we_d    = cpu_we_i;
                    sel_d   = cpu_sel_i;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    drop     = 1'b1;
                    rd_buf_d = '0;
                    state_d  = IDLE;
                end else if (wb_ack_i) begin
                    drop = 1'b1;
                    if (!we_q) begin
                        rd_buf_d   = wb_dat_i;
                        cpu_data_o = wb_dat_i;
                    end
                    state_d = (|stall_i) ? WAIT_STALL : IDLE;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    drop     = 1'b1;
                    rd_buf_d = '0;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    stallreq_o = 1'b1;
                    // Saturate rather than wrap when the timeout is disabled.
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WAIT_STALL: begin
                cpu_data_o = rd_buf_q;
                if (flush_i || stall_i == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (drop) begin
            cyc_d = 1'b0;
            we_d  = 1'b0;
            sel_d = '0;
            adr_d = '0;
            dat_d = '0;
        end
    end

    // State and registered Wishbone outputs; reset drops the cycle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rd_buf_q <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            cyc_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_buf_q <= rd_buf_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            cyc_q    <= cyc_d;
            err_q    <= err_d;
        end
    end

    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_stb_o  = cyc_q;
    assign wb_cyc_o  = cyc_q;
    assign bus_err_o = err_q;

endmodule

// File: doc/cpu_wb_bus_if.md
Name: cpu_wb_bus_if

Overview:
- Bridge between the CPU core's single-cycle SRAM-style data port and a Wishbone B3 classic master bus. Used for both instruction and data ports; one instance per port.
- Sits directly downstream of the core and upstream of the memories and peripherals.
- Turns each CPU access into one multi-cycle Wishbone cycle.
- Stalls the pipeline through stallreq_o until the access completes.
- Holds read data stable while the rest of the pipeline remains stalled.

Parameters:
- DW, 32: data/address width (matches `RegBus`).
- STALL_W, 6: width of pipeline stall vector.
- TIMEOUT, 255: ACK timeout in cycles. 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall_i  in  STALL_W  pipeline stall vector from the stall controller.
- flush_i  in  1  pipeline flush (exception); abandons any access in progress.
- cpu_ce_i  in  1  CPU access request.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_addr_i  in  DW  byte address.
- cpu_sel_i  in  4  byte lanes.
- cpu_data_i  in  DW  write data.
- cpu_data_o  out  DW  read data to CPU (combinational).
- stallreq_o  out  1  stall request to stall controller (combinational).
- bus_err_o  out  1  one-cycle pulse on ACK timeout.
- wb_adr_o  out  DW  Wishbone address.
- wb_dat_o  out  DW  Wishbone write data.
- wb_we_o  out  1  Wishbone write enable.
- wb_sel_o  out  4  Wishbone byte selects.
- wb_stb_o  out  1  Wishbone strobe.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_dat_i  in  DW  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; timeout counter=0; rd_buf=0.
  - All wb_* outputs are 0.
  - bus_err_o=0.
- States:
  - IDLE: no cycle in progress.
  - BUSY: Wishbone cycle in progress.
  - WAIT_STALL: access done, pipeline still stalled by another source.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0: register addr/data/we/sel onto wb_*, set stb=cyc=1, clear counter, go to BUSY.
  - Combinational outputs: stallreq_o = cpu_ce_i & ~flush_i; cpu_data_o=0.
- BUSY, wb_ack_i=1:
  - Next edge: stb=cyc=we=0, sel=0, adr=dat=0.
  - If read, rd_buf <= wb_dat_i.
  - Go to WAIT_STALL if stall_i != 0, else IDLE.
  - Same cycle: stallreq_o=0; cpu_data_o = we ? 0 : wb_dat_i.
- BUSY, wb_ack_i=0:
  - stallreq_o=1; counter increments.
  - If TIMEOUT != 0 and counter reaches TIMEOUT-1 on this cycle:
    - Abort: drop stb/cyc.
    - rd_buf <= 0; bus_err_o=1 for the next cycle only.
    - Go to IDLE.
    - stallreq_o=0 in the timeout cycle; cpu_data_o=0.
- Flush in BUSY:
  - flush_i=1 has priority over ack and timeout.
  - Drop stb/cyc next edge, rd_buf <= 0, go to IDLE.
  - stallreq_o=0 in that cycle.
- WAIT_STALL:
  - stallreq_o=0; cpu_data_o=rd_buf.
  - When stall_i==0, go to IDLE next edge.
  - flush_i=1 also forces IDLE.
- Wishbone outputs are registered and held constant for the whole cycle; never two cycles back-to-back without passing through IDLE.
  - Minimum access: 2 clocks (issue, ack). Pipeline penalty: 1 + wait states.
- Reset asserted mid-cycle:
  - Immediate async return to IDLE with stb/cyc=0.
  - Any late ack is ignored.
- wb_ack_i while in IDLE or WAIT_STALL is ignored.
- Counter width is ceil(log2(TIMEOUT+1)). Saturates when TIMEOUT=0 (no wrap effect).

Decomposition:
- Shared package/defines:
  - State encodings IDLE=2'b00, BUSY=2'b01, WAIT_STALL=2'b10.
  - `RegBus`, `ZeroWord`, stall vector width.
- Single module; no sub-module needed.
- The top-level SOPC instantiates two copies (iwishbone, dwishbone) plus a bus interconnect.

Test Plan:
- Read, 2 wait states: ce=1, we=0, addr=0x0000_0010, ack on 3rd BUSY cycle with dat=0xDEAD_BEEF.
  - stallreq high 3 cycles, then cpu_data_o=0xDEAD_BEEF in the ack cycle.
  - cyc/stb low the next edge.
- Write with zero wait: ce=1, we=1, sel=4'b0011, data=0x1234_5678, ack in first BUSY cycle.
  - wb_* carry exact values for 1 cycle; stallreq 1 cycle.
  - cpu_data_o=0.
- Held by stall: read ack with dat=0xA5A5_0001 while stall_i=6'b000111 for 3 more cycles.
  - State is WAIT_STALL; cpu_data_o=0xA5A5_0001 every cycle; stallreq_o=0.
  - Returns to IDLE when stall_i=0.
- Flush: flush_i=1 in the 2nd BUSY cycle, ack arrives simultaneously.
  - stb/cyc drop next edge; rd_buf=0; no data returned.
  - Next request issues normally.
- Timeout: TIMEOUT=8, never ack.
  - Abort after 8 BUSY cycles; bus_err_o pulses exactly 1 cycle; stallreq_o falls.
- Async reset mid-BUSY: rst pulses for 1 ns between edges.
  - wb_cyc_o=0 immediately; state IDLE.
  - A subsequent stray ack produces no effect.
